// File: rtl/core_wb_arbiter.sv
// Register-file write-port arbiter: in-order writeback vs. buffered long-latency results.
// Writeback has priority; a starvation counter forces a bubble so buffered results retire.
package rv;
    typedef logic [4:0] regaddr_t;
endpackage

module core_wb_arbiter
    import rv::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic        wb_wen,
    input  regaddr_t    wb_rd,
    input  logic [31:0] wb_wdata,
    output logic        wb_ready,
    input  logic        ll_valid,
    output logic        ll_ready,
    input  regaddr_t    ll_rd,
    input  logic [31:0] ll_wdata,
    output logic [31:0] ll_pending,
    output logic        rf_wen,
    output regaddr_t    rf_waddr,
    output logic [31:0] rf_wdata
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    regaddr_t      fifo_rd   [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   count;
    logic [CW-1:0] starve_cnt;

    logic empty;
    logic full;
    logic wb_use;
    logic head_grant;
    logic bypass;
    logic push;

    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign wb_ready = (starve_cnt != LIMIT);
    assign ll_ready = !full;

    assign wb_use     = wb_valid && wb_wen && wb_ready;
    assign head_grant = !wb_use && !empty;
    assign bypass     = !wb_use && empty && ll_valid;
    // x0 results complete the handshake but are never buffered
    assign push       = ll_valid && ll_ready && !bypass &&
                        (ll_rd != '0);

    always_comb begin
        rf_wen   = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (wb_use) begin
            rf_wen   = (wb_rd != '0);
            rf_waddr = wb_rd;
            rf_wdata = wb_wdata;
        end else if (head_grant) begin
            rf_wen   = 1'b1;
            rf_waddr = fifo_rd[rd_ptr[AW-1:0]];
            rf_wdata = fifo_data[rd_ptr[AW-1:0]];
        end else if (bypass) begin
            rf_wen   = (ll_rd != '0);
            rf_waddr = ll_rd;
            rf_wdata = ll_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr[AW-1:0]]   <= ll_rd;
            fifo_data[wr_ptr[AW-1:0]] <= ll_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            starve_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (head_grant) rd_ptr <= rd_ptr + (AW+1)'(1);
            if (empty || head_grant) starve_cnt <= '0;
            else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + CW'(1);
        end
    end

    // only live entries (offset from head below occupancy) contribute
    always_comb begin
        ll_pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((AW+1)'(i) < count)
                ll_pending[fifo_rd[rd_ptr[AW-1:0] + AW'(i)]] = 1'b1;
        end
        ll_pending[0] = 1'b0;
    end

endmodule

// File: tb/tb_core_wb_arbiter.sv
// Self-checking bench for core_wb_arbiter: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_core_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic        wb_wen;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wdata;
    logic        wb_ready;
    logic        ll_valid;
    logic        ll_ready;
    logic [4:0]  ll_rd;
    logic [31:0] ll_wdata;
    logic [31:0] ll_pending;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int total = 0;
    int bad   = 0;

    logic [71:0] obs;
    logic [71:0] exp_v;

    core_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_valid   (wb_valid),
        .wb_wen     (wb_wen),
        .wb_rd      (wb_rd),
        .wb_wdata   (wb_wdata),
        .wb_ready   (wb_ready),
        .ll_valid   (ll_valid),
        .ll_ready   (ll_ready),
        .ll_rd      (ll_rd),
        .ll_wdata   (ll_wdata),
        .ll_pending (ll_pending),
        .rf_wen     (rf_wen),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata)
    );

    always #5 clk = ~clk;

    // {wb_ready, ll_ready, rf_wen, addr, data, pending}; addr/data masked when idle
    assign obs = {wb_ready, ll_ready, rf_wen,
                  rf_wen ? rf_waddr : 5'd0,
                  rf_wen ? rf_wdata : 32'd0,
                  ll_pending};

    task automatic drive(input logic wv, input logic wen,
                         input logic [4:0] wrd, input logic [31:0] wd,
                         input logic lv, input logic [4:0] lrd,
                         input logic [31:0] ld);
        wb_valid = wv;
        wb_wen   = wen;
        wb_rd    = wrd;
        wb_wdata = wd;
        ll_valid = lv;
        ll_rd    = lrd;
        ll_wdata = ld;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(1, 1, 5'd4, 32'hA5, 0, 5'd0, 32'd0);
        #1;
        exp_v = {1'b1, 1'b1, 1'b1, 5'd4, 32'hA5, 32'h0};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL reset_wb_pass got=%h want=%h", obs, exp_v);
        end
        drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        exp_v = {1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL reset_idle got=%h want=%h", obs, exp_v);
        end
    endtask

    task automatic test_bypass;
        @(negedge clk);
        drive(0, 0, 5'd0, 32'd0, 1, 5'd5, 32'hDEADBEEF);
        #1;
        exp_v = {1'b1, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 32'h0};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL bypass_write got=%h want=%h", obs, exp_v);
        end
        @(negedge clk);
        drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        #1;
        exp_v = {1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL bypass_after got=%h want=%h", obs, exp_v);
        end
    endtask

    task automatic test_collision;
        @(negedge clk);
        drive(1, 1, 5'd3, 32'h11, 1, 5'd7, 32'h22);
        #1;
        exp_v = {1'b1, 1'b1, 1'b1, 5'd3, 32'h11, 32'h0};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL collide_wb got=%h want=%h", obs, exp_v);
        end
        @(negedge clk);
        drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        #1;
        exp_v = {1'b1, 1'b1, 1'b1, 5'd7, 32'h22, 32'h80};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL collide_drain got=%h want=%h", obs, exp_v);
        end
        @(negedge clk);
        #1;
        exp_v = {1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL collide_empty got=%h want=%h", obs, exp_v);
        end
    endtask

    task automatic test_fill_starve;
        logic [4:0]  lrd;
        logic [31:0] pend;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            lrd = (c == 0) ? 5'd1 : (c == 1) ? 5'd2 : 5'd3;
            drive(1, 1, 5'd20, 32'h55, 1, lrd, 32'd100 + 32'(lrd));
            #1;
            if (c == 0)      pend = 32'h0;
            else if (c == 1) pend = 32'h2;
            else if (c < 6)  pend = 32'h6;
            else             pend = 32'h4;
            exp_v = {(c != 5), (c < 2 || c == 6), 1'b1,
                     (c == 5) ? 5'd1 : 5'd20,
                     (c == 5) ? 32'd101 : 32'h55,
                     pend};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL fill_starve c=%0d got=%h want=%h", c, obs, exp_v);
            end
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
            #1;
            if (c == 0)      exp_v = {1'b1, 1'b0, 1'b1, 5'd2, 32'd102, 32'hC};
            else if (c == 1) exp_v = {1'b1, 1'b1, 1'b1, 5'd3, 32'd103, 32'h8};
            else             exp_v = {1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 32'h0};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL fill_drain c=%0d got=%h want=%h", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_x0;
        @(negedge clk);
        drive(0, 0, 5'd0, 32'd0, 1, 5'd0, 32'd77);
        #1;
        exp_v = {1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL x0_bypass got=%h want=%h", obs, exp_v);
        end
        @(negedge clk);
        drive(1, 1, 5'd9, 32'd99, 1, 5'd0, 32'd78);
        #1;
        exp_v = {1'b1, 1'b1, 1'b1, 5'd9, 32'd99, 32'h0};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL x0_busy got=%h want=%h", obs, exp_v);
        end
        @(negedge clk);
        drive(1, 1, 5'd0, 32'd33, 0, 5'd0, 32'd0);
        #1;
        exp_v = {1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL x0_wb got=%h want=%h", obs, exp_v);
        end
        @(negedge clk);
        drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        #1;
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL x0_after got=%h want=%h", obs, exp_v);
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        drive(1, 1, 5'd20, 32'd1, 1, 5'd4, 32'd44);
        #1;
        exp_v = {1'b1, 1'b1, 1'b1, 5'd20, 32'd1, 32'h0};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL ar_fill0 got=%h want=%h", obs, exp_v);
        end
        @(negedge clk);
        drive(1, 1, 5'd21, 32'd2, 1, 5'd5, 32'd55);
        #1;
        exp_v = {1'b1, 1'b1, 1'b1, 5'd21, 32'd2, 32'h10};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL ar_fill1 got=%h want=%h", obs, exp_v);
        end
        @(negedge clk);
        drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        #1;
        exp_v = {1'b1, 1'b0, 1'b1, 5'd4, 32'd44, 32'h30};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL ar_full got=%h want=%h", obs, exp_v);
        end
        #2 rst = 1'b1;
        #1;
        exp_v = {1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL ar_immediate got=%h want=%h", obs, exp_v);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL ar_dropped c=%0d got=%h want=%h", c, obs, exp_v);
            end
        end
    endtask

    task automatic test_random;
        logic [4:0]  q_rd[$];
        logic [31:0] q_d[$];
        int          wait_cnt;
        bit          wb_keep;
        bit          ll_keep;
        bit          exp_wbr;
        bit          exp_llr;
        bit          wb_go;
        bit          head_go;
        bit          byp;
        bit          exp_wen;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        logic [31:0] exp_pend;
        int          sz;
        wait_cnt = 0;
        wb_keep  = 0;
        ll_keep  = 0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (!wb_keep) begin
                wb_valid = ($urandom_range(0, 99) < 70);
                wb_wen   = ($urandom_range(0, 3) != 0);
                wb_rd    = ($urandom_range(0, 3) == 0) ? 5'd0 :
                           5'(16 + $urandom_range(0, 15));
                wb_wdata = $urandom;
            end
            if (!ll_keep) begin
                ll_valid = ($urandom_range(0, 99) < 45);
                ll_rd    = 5'($urandom_range(0, 15));
                ll_wdata = $urandom;
            end
            #1;
            sz       = q_rd.size();
            exp_wbr  = (wait_cnt < LIMIT);
            exp_llr  = (sz < DEPTH);
            exp_pend = 32'h0;
            foreach (q_rd[k]) exp_pend[q_rd[k]] = 1'b1;
            wb_go    = wb_valid && wb_wen && exp_wbr;
            head_go  = !wb_go && (sz > 0);
            byp      = !wb_go && (sz == 0) && ll_valid;
            exp_wen  = 1'b0;
            exp_addr = 5'd0;
            exp_data = 32'd0;
            if (wb_go && wb_rd != 5'd0) begin
                exp_wen  = 1'b1;
                exp_addr = wb_rd;
                exp_data = wb_wdata;
            end else if (head_go) begin
                exp_wen  = 1'b1;
                exp_addr = q_rd[0];
                exp_data = q_d[0];
            end else if (byp && ll_rd != 5'd0) begin
                exp_wen  = 1'b1;
                exp_addr = ll_rd;
                exp_data = ll_wdata;
            end
            exp_v = {exp_wbr, exp_llr, exp_wen, exp_addr, exp_data, exp_pend};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL random n=%0d got=%h want=%h", n, obs, exp_v);
            end
            total++;
            if (wb_valid && wb_wen && wb_ready && wb_rd != 5'd0 &&
                ll_pending[wb_rd] === 1'b1) begin
                bad++;
                $display("FAIL order n=%0d rd=%0d pending=%h", n, wb_rd, ll_pending);
            end
            if (head_go) begin
                void'(q_rd.pop_front());
                void'(q_d.pop_front());
            end
            if (ll_valid && exp_llr && !byp && ll_rd != 5'd0) begin
                q_rd.push_back(ll_rd);
                q_d.push_back(ll_wdata);
            end
            if (sz == 0 || head_go) wait_cnt = 0;
            else if (wait_cnt < LIMIT) wait_cnt++;
            wb_keep = wb_valid && !exp_wbr;
            ll_keep = ll_valid && !exp_llr;
        end
        @(negedge clk);
        drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_collision();
        test_fill_starve();
        test_x0();
        test_async_reset();
        test_random();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
